// File: rtl/counter_down_reload.sv
// Loadable down-counter/timer with underflow pulse, one-shot expiry flag and
// periodic auto-reload from a captured start value.
module counter_down_reload #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             MODE,
  output logic [WIDTH-1:0] counter,
  output logic             UF,
  output logic             DONE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] counter_d;
  logic [WIDTH-1:0] reload_d;
  logic             uf_d;
  logic             done_d;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      counter    <= '0;
      reload_reg <= '0;
      UF         <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= next_state;
      counter    <= counter_d;
      reload_reg <= reload_d;
      UF         <= uf_d;
      DONE       <= done_d;
    end
  end

  // Priority CLR > LOAD > count; UF defaults low so it can only last one cycle.
  always_comb begin
    next_state = state;
    counter_d  = counter;
    reload_d   = reload_reg;
    uf_d       = 1'b0;
    done_d     = DONE;

    if (CLR) begin
      counter_d  = '0;
      done_d     = 1'b0;
      next_state = IDLE;
    end else if (LOAD) begin
      counter_d = LOAD_VAL;
      reload_d  = LOAD_VAL;
      done_d    = 1'b0;
      if (LOAD_VAL != '0) begin
        next_state = RUN;
      end else begin
        next_state = IDLE;
      end
    end else begin
      case (state)
        RUN: begin
          if (EN) begin
            if (counter != '0) begin
              counter_d = counter - WIDTH'(1);
            end else begin
              // Reaching zero is not the underflow; the enabled edge at zero is.
              uf_d = 1'b1;
              if (MODE) begin
                counter_d = reload_reg;
              end else begin
                counter_d  = '0;
                done_d     = 1'b1;
                next_state = EXPIRED;
              end
            end
          end
        end
        EXPIRED: begin
          counter_d = '0;
          done_d    = 1'b1;
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  assign BUSY = (state == RUN);

endmodule

// File: tb/tb_counter_down_reload.sv
// Directed self-checking bench for counter_down_reload.
module tb_counter_down_reload;

  logic       clk;
  logic       Reset;
  logic       EN;
  logic       CLR;
  logic       LOAD;
  logic [7:0] LOAD_VAL;
  logic       MODE;
  logic [7:0] counter;
  logic       UF;
  logic       DONE;
  logic       BUSY;

  int checks;
  int errors;

  counter_down_reload #(.WIDTH(8)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .EN       (EN),
    .CLR      (CLR),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .MODE     (MODE),
    .counter  (counter),
    .UF       (UF),
    .DONE     (DONE),
    .BUSY     (BUSY)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if (counter !== 8'h00 || UF !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: got cnt=%h uf=%b done=%b busy=%b want 00 0 0 0",
               counter, UF, DONE, BUSY);
    end
    Reset = 1'b1;
    step();
    LOAD = 1'b1; LOAD_VAL = 8'h40; MODE = 1'b0; EN = 1'b1;
    step();
    LOAD = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (counter !== 8'h37 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_precount: got cnt=%h busy=%b want 37 1", counter, BUSY);
    end
    #20;
    Reset = 1'b0;
    #5;
    checks++;
    if (counter !== 8'h00 || UF !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midrun: got cnt=%h uf=%b done=%b busy=%b want 00 0 0 0",
               counter, UF, DONE, BUSY);
    end
    #5;
    Reset = 1'b1;
    EN = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_cnt [3];
    exp_cnt[0] = 8'h02; exp_cnt[1] = 8'h01; exp_cnt[2] = 8'h00;
    LOAD = 1'b1; LOAD_VAL = 8'h03; MODE = 1'b0; EN = 1'b1;
    step();
    LOAD = 1'b0;
    checks++;
    if (counter !== 8'h03 || BUSY !== 1'b1 || UF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_load: got cnt=%h busy=%b uf=%b want 03 1 0", counter, BUSY, UF);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (counter !== exp_cnt[i] || UF !== 1'b0 || DONE !== 1'b0) begin
        errors++;
        $display("[TB] FAIL oneshot_count%0d: got cnt=%h uf=%b done=%b want %h 0 0",
                 i, counter, UF, DONE, exp_cnt[i]);
      end
    end
    step();
    checks++;
    if (counter !== 8'h00 || UF !== 1'b1 || DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_uf: got cnt=%h uf=%b done=%b busy=%b want 00 1 1 0",
               counter, UF, DONE, BUSY);
    end
    step();
    checks++;
    if (UF !== 1'b0 || DONE !== 1'b1 || counter !== 8'h00) begin
      errors++;
      $display("[TB] FAIL oneshot_after: got cnt=%h uf=%b done=%b want 00 0 1", counter, UF, DONE);
    end
  endtask

  task automatic test_expired();
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (counter !== 8'h00 || DONE !== 1'b1 || BUSY !== 1'b0 || UF !== 1'b0) begin
        errors++;
        $display("[TB] FAIL expired_hold%0d: got cnt=%h done=%b busy=%b uf=%b want 00 1 0 0",
                 i, counter, DONE, BUSY, UF);
      end
    end
    LOAD = 1'b1; LOAD_VAL = 8'h04;
    step();
    LOAD = 1'b0;
    checks++;
    if (counter !== 8'h04 || DONE !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL expired_reload: got cnt=%h done=%b busy=%b want 04 0 1", counter, DONE, BUSY);
    end
    step();
    checks++;
    if (counter !== 8'h03) begin
      errors++;
      $display("[TB] FAIL expired_resume: got cnt=%h want 03", counter);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp_cnt [12];
    logic       exp_uf  [12];
    int         pulses;
    for (int i = 0; i < 12; i++) begin
      exp_cnt[i] = (i % 3 == 0) ? 8'h01 : (i % 3 == 1) ? 8'h00 : 8'h02;
      exp_uf[i]  = (i % 3 == 2);
    end
    pulses = 0;
    LOAD = 1'b1; LOAD_VAL = 8'h02; MODE = 1'b1; EN = 1'b1;
    step();
    LOAD = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (UF === 1'b1) pulses++;
      checks++;
      if (counter !== exp_cnt[i] || UF !== exp_uf[i] || BUSY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL periodic_cyc%0d: got cnt=%h uf=%b busy=%b want %h %b 1",
                 i, counter, UF, BUSY, exp_cnt[i], exp_uf[i]);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("[TB] FAIL periodic_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_en_gating();
    logic [7:0] exp_cnt;
    logic       exp_uf;
    int         first_uf;
    exp_cnt  = 8'hFF;
    first_uf = -1;
    LOAD = 1'b1; LOAD_VAL = 8'hFF; MODE = 1'b1; EN = 1'b0;
    step();
    LOAD = 1'b0;
    for (int i = 1; i <= 520; i++) begin
      EN = (i % 2 == 1);
      exp_uf = 1'b0;
      if (EN) begin
        if (exp_cnt == 8'h00) begin
          exp_uf  = 1'b1;
          exp_cnt = 8'hFF;
        end else begin
          exp_cnt = exp_cnt - 8'h01;
        end
      end
      step();
      if (UF === 1'b1 && first_uf < 0) first_uf = i;
      checks++;
      if (counter !== exp_cnt || UF !== exp_uf) begin
        errors++;
        $display("[TB] FAIL gating_clk%0d: got cnt=%h uf=%b want %h %b", i, counter, UF, exp_cnt, exp_uf);
      end
      if (first_uf < 0 && counter === 8'hFF) begin
        checks++;
        errors++;
        $display("[TB] FAIL gating_wrap: got cnt=ff at clk %0d before reload, want no ff", i);
      end
    end
    checks++;
    if (first_uf != 511) begin
      errors++;
      $display("[TB] FAIL gating_first_uf: got clk %0d want 511", first_uf);
    end
    EN = 1'b0;
  endtask

  task automatic test_priority();
    LOAD = 1'b1; LOAD_VAL = 8'h20; MODE = 1'b0; EN = 1'b1;
    step();
    LOAD = 1'b0;
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (counter !== 8'h10) begin
      errors++;
      $display("[TB] FAIL prio_precount: got cnt=%h want 10", counter);
    end
    CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 8'h55;
    step();
    CLR = 1'b0; LOAD = 1'b0;
    checks++;
    if (counter !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0 || UF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_clr_load: got cnt=%h busy=%b done=%b uf=%b want 00 0 0 0",
               counter, BUSY, DONE, UF);
    end
    LOAD = 1'b1; LOAD_VAL = 8'h01;
    step();
    LOAD = 1'b0;
    step();
    checks++;
    if (counter !== 8'h00 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_pending: got cnt=%h busy=%b want 00 1", counter, BUSY);
    end
    LOAD = 1'b1; LOAD_VAL = 8'h05;
    step();
    LOAD = 1'b0;
    checks++;
    if (counter !== 8'h05 || UF !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_load_vs_uf: got cnt=%h uf=%b done=%b busy=%b want 05 0 0 1",
               counter, UF, DONE, BUSY);
    end
    LOAD = 1'b1; LOAD_VAL = 8'h00;
    step();
    LOAD = 1'b0;
    checks++;
    if (counter !== 8'h00 || BUSY !== 1'b0 || UF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_load_zero: got cnt=%h busy=%b uf=%b want 00 0 0", counter, BUSY, UF);
    end
    step();
    checks++;
    if (counter !== 8'h00 || BUSY !== 1'b0 || UF !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_idle_hold: got cnt=%h busy=%b uf=%b done=%b want 00 0 0 0",
               counter, BUSY, UF, DONE);
    end
    EN = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Reset    = 1'b1;
    EN       = 1'b0;
    CLR      = 1'b0;
    LOAD     = 1'b0;
    LOAD_VAL = 8'h00;
    MODE     = 1'b0;
    #5;
    Reset = 1'b0;
    test_reset();
    test_one_shot();
    test_expired();
    test_periodic();
    test_en_gating();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
